drive_sync_fifo: RTL and testbench
==================================

DRIVE_SYNC_FIFO -- requirements
Module: drive_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the bundled data word.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flops in the i_drive synchronizer; at least 2.
REQ-004 SHALL have parameter FREE_PULSE, default 2, o_free high time in clk cycles; at least 1.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit, reset that is synchronous and active-low.
REQ-007 SHALL have port i_drive, input, 1 bit, request level from the upstream merge's o_driveNext.
REQ-008 SHALL have port i_data, input, DATA_WIDTH bits, bundled data; stable from i_drive rise until o_free.
REQ-009 SHALL have port o_free, output, 1 bit, acknowledge to upstream i_freeNext.
REQ-010 SHALL have port o_valid, output, 1 bit, head entry available.
REQ-011 SHALL have port i_ready, input, 1 bit, consumer accepts the head entry.
REQ-012 SHALL have port o_data, output, DATA_WIDTH bits, head entry (first-word fall-through).
REQ-013 SHALL have port o_count, output, clog2(DEPTH+1) bits, occupied entries.

Function
REQ-014 i_drive SHALL pass through a SYNC_STAGES flop synchronizer; drv_s is the last stage; no other logic SHALL read i_drive.
REQ-015 Control FSM states SHALL be IDLE, STALL, ACK and WAIT_LOW.
REQ-016 In IDLE with drv_s=1 and space available, the FSM SHALL write i_data at the next edge, enter ACK, and set o_free=1 at that same edge.
REQ-017 Space available SHALL mean count<DEPTH, or count==DEPTH with a pop in the same cycle.
REQ-018 In IDLE with drv_s=1 and no space, the FSM SHALL enter STALL with o_free=0; in STALL it SHALL write and enter ACK on the first cycle with space.
REQ-019 ACK SHALL hold o_free=1 for exactly FREE_PULSE cycles, then enter WAIT_LOW with o_free=0.
REQ-020 WAIT_LOW SHALL return to IDLE only when drv_s=0, so one drive level yields exactly one write.
REQ-021 Latency: if i_drive is first sampled high at edge k (SYNC_STAGES=2, FIFO not full), the write and o_free rise SHALL occur at edge k+2, and o_valid SHALL be 1 after edge k+2.
REQ-022 o_valid SHALL equal (count!=0); a pop SHALL occur when o_valid&i_ready; o_data SHALL show the oldest entry.
REQ-023 A simultaneous push and pop SHALL leave count unchanged, including at count==DEPTH and at count==1.
REQ-024 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-025 i_ready while empty SHALL be ignored.
REQ-026 A push into an empty FIFO SHALL NOT be visible on o_data in the same cycle; there is no bypass path.

Reset
REQ-027 While rstn=0 at a clk edge: synchronizer=0, FSM=IDLE, pointers=0, count=0, o_free=0, o_valid=0, o_count=0.
REQ-028 o_data reset value SHALL be don't-care; the storage array SHALL NOT be reset.
REQ-029 Reset during STALL, ACK or WAIT_LOW SHALL abort the transaction and drop o_free immediately after the edge.
REQ-030 An i_drive held high across reset release SHALL be treated as a new request.

Structure
REQ-031 Package drive_sync_pkg SHALL hold the FSM state enum and the count-width function.
REQ-032 The synchronizer SHALL be sub-module bit_sync (parameter STAGES, ports clk, rstn, d, q); the FIFO storage SHALL stay inline.

Verification
REQ-033 Single transfer: i_drive=1 with data 0xA5A5_0001, i_ready=1 -> o_free high 2 cycles starting at edge k+2; o_data=0xA5A5_0001 with o_valid=1 for exactly one cycle.
REQ-034 Fill: i_ready=0 and five drive transactions 0x1..0x5 -> writes 1-4 acked, o_count=4, 5th in STALL with o_free=0; one i_ready pulse pops 0x1 and in the same cycle writes 0x5, o_count stays 4, then o_free rises.
REQ-035 Held drive: i_drive high for 20 cycles -> exactly one write; after i_drive falls and rises again, exactly one more write.
REQ-036 Wrap: 10 sequential transactions with i_ready=1 at DEPTH=4 -> output order 0..9, no loss or duplication, o_count never above 4.
REQ-037 Mid-reset: rstn=0 for 1 cycle during ACK -> o_free=0, o_valid=0 and o_count=0 next cycle; a new drive afterwards completes normally.

Source files
------------

// File: rtl/drive_sync_pkg.sv
// drive_sync_pkg: shared FSM state type and count-width helper for drive_sync_fifo
package drive_sync_pkg;
  typedef enum logic [1:0] {IDLE, STALL, ACK, WAIT_LOW} state_t;
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/drive_sync_fifo_bit_sync.sv
// bit_sync: multi-flop level synchronizer with synchronous active-low clear
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;
  always_ff @(posedge clk) begin
    if (!rstn) sr <= '0;
    else sr <= {sr[STAGES-2:0], d};
  end
  assign q = sr[STAGES-1];
endmodule

// File: rtl/drive_sync_fifo.sv
// drive_sync_fifo: level-handshake (drive/free) receiver feeding a first-word fall-through FIFO
module drive_sync_fifo
  import drive_sync_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FREE_PULSE  = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_drive,
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic                          o_free,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [count_width(DEPTH)-1:0] o_count
);
  localparam int CW = count_width(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FREE_PULSE + 1);
  logic                  drv_s, push, pop, space;
  state_t                state, state_n;
  logic [PW-1:0]         pcnt;
  logic [AW-1:0]         wp, rp;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rstn(rstn), .d(i_drive), .q(drv_s));
  assign pop     = o_valid & i_ready;
  assign space   = (o_count < CW'(DEPTH)) | pop;
  assign o_valid = o_count != '0;
  assign o_free  = state == ACK;
  assign o_data  = mem[rp];
  always_comb begin
    state_n = state;
    push    = 1'b0;
    case (state)
      IDLE: begin
        push    = drv_s & space;
        state_n = drv_s ? (space ? ACK : STALL) : IDLE;
      end
      STALL: begin
        push    = space;
        state_n = space ? ACK : STALL;
      end
      ACK:     state_n = (pcnt == PW'(FREE_PULSE - 1)) ? WAIT_LOW : ACK;
      default: state_n = drv_s ? WAIT_LOW : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      pcnt    <= '0;
      wp      <= '0;
      rp      <= '0;
      o_count <= '0;
    end else begin
      state   <= state_n;
      pcnt    <= (state == ACK) ? pcnt + PW'(1) : '0;
      wp      <= push ? wp + AW'(1) : wp;
      rp      <= pop ? rp + AW'(1) : rp;
      o_count <= o_count + CW'(push) - CW'(pop);
    end
  end
  // storage is deliberately left out of reset; o_data is only meaningful with o_valid
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= i_data;
  end
endmodule

// File: tb/tb_drive_sync_fifo.sv
// tb_drive_sync_fifo: randomized and directed checks of drive_sync_fifo against a queue-based model
module tb_drive_sync_fifo;
  localparam int DW = 32, DEPTH = 4, SS = 2, FP = 2;
  logic clk = 1'b0, rstn = 1'b0, i_drive = 1'b0, i_ready = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic o_free, o_valid;
  logic [DW-1:0] o_data;
  logic [2:0] o_count;
  int total = 0, bad = 0, acks = 0;
  logic free_q = 1'b0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] popped[$];
  logic [SS-1:0] hist = '0;
  bit served = 0, want = 0;
  int ack_left = 0;

  drive_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS), .FREE_PULSE(FP)) dut (
    .clk(clk), .rstn(rstn), .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_count(o_count));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One accepted request per drive level; a pending request waits for room,
  // then free stays up FP cycles and a new request needs the level to drop first.
  task automatic model_edge();
    bit drv, pop, space, req, push;
    if (!rstn) begin
      q.delete();
      hist = '0; served = 0; want = 0; ack_left = 0;
      return;
    end
    drv   = hist[SS-1];
    pop   = q.size() > 0 && i_ready;
    space = q.size() < DEPTH || pop;
    req   = want || (!served && ack_left == 0 && drv);
    push  = req && space;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(i_data);
    want = req && !space;
    if (push) begin served = 1; ack_left = FP; end
    else if (ack_left > 0) ack_left--;
    else if (served && !drv) served = 0;
    hist = {hist[SS-2:0], i_drive};
  endtask

  task automatic tick();
    logic pv, rs;
    logic [DW-1:0] d;
    pv = o_valid & i_ready; d = o_data; rs = rstn;
    @(posedge clk);
    model_edge();
    #1;
    if (pv && rs) popped.push_back(d);
    if (o_free && !free_q) acks++;
    free_q = o_free;
    check("free", DW'(o_free), DW'(ack_left > 0));
    check("valid", DW'(o_valid), DW'(q.size() > 0));
    check("count", DW'(o_count), DW'(q.size()));
    if (q.size() > 0) check("data", o_data, q[0]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic xact(input logic [DW-1:0] d);
    int n;
    i_data = d; i_drive = 1'b1;
    n = 0;
    while (!o_free && n < 30) begin tick(); n++; end
    if (n >= 30) check("free_timeout", 0, 1);
    i_drive = 1'b0;
    n = 0;
    while (o_free && n < 30) begin tick(); n++; end
    ticks(3);
  endtask

  initial begin
    ticks(3);
    check("rst_free", DW'(o_free), 0);
    check("rst_count", DW'(o_count), 0);
    rstn = 1'b1;
    ticks(2);
    // single transfer: free rises two edges after first sampling
    i_ready = 1'b1; i_data = 32'hA5A5_0001; i_drive = 1'b1;
    tick(); tick();
    check("lat_free_k1", DW'(o_free), 0);
    tick();
    check("lat_free_k2", DW'(o_free), 1);
    check("lat_valid_k2", DW'(o_valid), 1);
    check("lat_data", o_data, 32'hA5A5_0001);
    ticks(6); i_drive = 1'b0; ticks(4);
    // fill to full then stall the fifth request
    i_ready = 1'b0;
    for (int i = 1; i <= 4; i++) xact(DW'(i));
    check("full_count", DW'(o_count), 4);
    i_data = 32'h5; i_drive = 1'b1;
    ticks(8);
    check("stall_free", DW'(o_free), 0);
    i_ready = 1'b1; tick(); i_ready = 1'b0;
    check("swap_count", DW'(o_count), 4);
    check("swap_free", DW'(o_free), 1);
    check("swap_head", o_data, 32'h2);
    i_drive = 1'b0; ticks(4);
    i_ready = 1'b1; ticks(8);
    check("drained", DW'(o_count), 0);
    // held drive: one write per level
    acks = 0; i_ready = 1'b0; i_data = 32'h77; i_drive = 1'b1;
    ticks(20); i_drive = 1'b0; ticks(6);
    check("held_acks1", DW'(acks), 1);
    i_data = 32'h78; i_drive = 1'b1; ticks(10); i_drive = 1'b0; ticks(6);
    check("held_acks2", DW'(acks), 2);
    check("held_count", DW'(o_count), 2);
    i_ready = 1'b1; ticks(4);
    // wrap: ten sequential transfers emerge in order
    popped.delete();
    for (int i = 0; i < 10; i++) xact(DW'(i));
    ticks(4);
    check("wrap_len", DW'(popped.size()), 10);
    for (int i = 0; i < popped.size() && i < 10; i++) check("wrap_order", popped[i], DW'(i));
    // reset during ACK aborts; held drive restarts as a new request
    i_ready = 1'b0; i_data = 32'hDEAD; i_drive = 1'b1;
    for (int n = 0; n < 10 && !o_free; n++) tick();
    rstn = 1'b0; tick(); rstn = 1'b1;
    check("mrst_free", DW'(o_free), 0);
    check("mrst_valid", DW'(o_valid), 0);
    check("mrst_count", DW'(o_count), 0);
    ticks(6); i_drive = 1'b0; ticks(4);
    check("mrst_retry", DW'(o_count), 1);
    xact(32'hBEEF);
    check("mrst_after", DW'(o_count), 2);
    // random traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        i_drive = ~i_drive;
        if (!i_drive) i_data = $urandom;
      end
      i_ready = $urandom_range(0, 2) == 0;
      rstn = $urandom_range(0, 199) != 0;
      tick();
    end
    rstn = 1'b1; i_drive = 1'b0; i_ready = 1'b1; ticks(12);
    check("final_count", DW'(o_count), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
